// File: rtl/idli_sqi_mem_m.sv
// SQI (quad SPI) byte-addressed memory slave: 0x03 read / 0x02 write, 16-bit address,
// one dummy byte before read data; SCK is oversampled on the system clock.
module idli_sqi_mem_m #(
    parameter int ADDR_W = 8  // 5..16: address nibbles are shifted straight into addr
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    typedef enum logic [2:0] {
        ST_INSTR,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t              state, state_d;
    logic [1:0]          cnt, cnt_d;
    logic                half, half_d;
    logic                sck_q;
    logic                is_read, is_read_d;
    logic [3:0]          instr_hi, instr_hi_d;
    logic [3:0]          held, held_d;
    logic [ADDR_W-1:0]   addr, addr_d;
    logic [3:0]          sio_q, sio_d;
    logic                oe_q, oe_d;
    logic                mem_we;
    logic                rise, fall;
    logic [7:0]          mem_byte;

    logic [7:0] mem [DEPTH];

    assign rise     = i_mem_sck & ~sck_q;
    assign fall     = ~i_mem_sck & sck_q;
    assign mem_byte = mem[addr];

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        half_d     = half;
        is_read_d  = is_read;
        instr_hi_d = instr_hi;
        held_d     = held;
        addr_d     = addr;
        sio_d      = sio_q;
        oe_d       = oe_q;
        mem_we     = 1'b0;

        // Chip select high overrides any SCK event seen in the same cycle.
        if (i_mem_cs) begin
            state_d = ST_INSTR;
            cnt_d   = 2'd0;
            half_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state)
                ST_INSTR: begin
                    if (rise) begin
                        if (cnt == 2'd0) begin
                            instr_hi_d = i_mem_sio;
                            cnt_d      = 2'd1;
                        end else begin
                            cnt_d = 2'd0;
                            if ({instr_hi, i_mem_sio} == 8'h03) begin
                                state_d   = ST_ADDR;
                                is_read_d = 1'b1;
                            end else if ({instr_hi, i_mem_sio} == 8'h02) begin
                                state_d   = ST_ADDR;
                                is_read_d = 1'b0;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        // Upper address nibbles shift out the top, so high bits alias.
                        addr_d = {addr[ADDR_W-5:0], i_mem_sio};
                        cnt_d  = cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            half_d  = 1'b0;
                            state_d = is_read ? ST_DUMMY : ST_WDATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (cnt == 2'd0) begin
                            cnt_d = 2'd1;
                        end else begin
                            cnt_d   = 2'd0;
                            state_d = ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (fall) begin
                        sio_d = half ? mem_byte[3:0] : mem_byte[7:4];
                        oe_d  = 1'b1;
                    end
                    if (rise) begin
                        half_d = ~half;
                        if (half) addr_d = addr + ADDR_W'(1);
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        half_d = ~half;
                        if (!half) begin
                            held_d = i_mem_sio;
                        end else begin
                            mem_we = 1'b1;
                            addr_d = addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;  // ST_IGNORE waits for chip select to rise
            endcase
            if (state_d != ST_RDATA) oe_d = 1'b0;
        end
    end

    always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
        if (i_mem_rst) begin
            state    <= ST_INSTR;
            cnt      <= 2'd0;
            half     <= 1'b0;
            sck_q    <= 1'b0;
            is_read  <= 1'b0;
            instr_hi <= 4'd0;
            held     <= 4'd0;
            addr     <= '0;
            sio_q    <= 4'd0;
            oe_q     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            half     <= half_d;
            sck_q    <= i_mem_sck;
            is_read  <= is_read_d;
            instr_hi <= instr_hi_d;
            held     <= held_d;
            addr     <= addr_d;
            sio_q    <= sio_d;
            oe_q     <= oe_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge i_mem_gck) begin
        if (mem_we) mem[addr] <= {held, i_mem_sio};
    end

    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed + randomized bench for idli_sqi_mem_m against a byte-array memory model.
module tb_idli_sqi_mem_m;

    logic       gck = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       oe;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl   [256];
    bit         known [256];
    logic [7:0] wbuf  [16];
    logic [3:0] rd_n;
    logic       rd_oe;
    logic       oe_or;

    idli_sqi_mem_m #(.ADDR_W(8)) dut (
        .i_mem_gck   (gck),
        .i_mem_rst   (rst),
        .i_mem_sck   (sck),
        .i_mem_cs    (cs),
        .i_mem_sio   (sio_in),
        .o_mem_sio   (sio_out),
        .o_mem_sio_oe(oe)
    );

    always #5 gck = ~gck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One SCK period: low phase (controller drives, slave shifts out), then rise.
    task automatic beat(input logic [3:0] nib);
        sck    = 1'b0;
        sio_in = nib;
        repeat (2) @(negedge gck);
        rd_n  = sio_out;
        rd_oe = oe;
        sck   = 1'b1;
        repeat (2) @(negedge gck);
    endtask

    task automatic send_byte(input logic [7:0] b);
        beat(b[7:4]);
        oe_or = rd_oe;
        beat(b[3:0]);
        oe_or = oe_or | rd_oe;
    endtask

    task automatic begin_txn(input logic [7:0] ins, input logic [15:0] a);
        cs = 1'b0;
        @(negedge gck);
        send_byte(ins);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic end_txn();
        sck = 1'b0;
        @(negedge gck);
        cs = 1'b1;
        repeat (2) @(negedge gck);
    endtask

    task automatic wr(input logic [15:0] a, input int n);
        int idx;
        begin_txn(8'h02, a);
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i]);
            idx        = (int'(a[7:0]) + i) % 256;
            mdl[idx]   = wbuf[i];
            known[idx] = 1'b1;
        end
        chk("wr_oe", 16'(oe_or), 16'd0);
        end_txn();
    endtask

    task automatic rd(input logic [15:0] a, input int n, input string tag);
        int idx;
        logic [3:0] hi;
        begin_txn(8'h03, a);
        send_byte(8'h00);
        for (int i = 0; i < n; i++) begin
            idx = (int'(a[7:0]) + i) % 256;
            beat(4'h0);
            hi = rd_n;
            chk({tag, "_oe_hi"}, 16'(rd_oe), 16'd1);
            beat(4'h0);
            chk({tag, "_oe_lo"}, 16'(rd_oe), 16'd1);
            if (known[idx]) chk(tag, 16'({hi, rd_n}), 16'(mdl[idx]));
        end
        end_txn();
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] r;
        int n;

        rst    = 1'b1;
        cs     = 1'b1;
        sck    = 1'b0;
        sio_in = 4'h0;
        repeat (3) @(negedge gck);
        chk("reset_oe", 16'(oe), 16'd0);
        chk("reset_sio", 16'(sio_out), 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge gck);

        // Basic write then read back.
        wbuf[0] = 8'hA5;
        wr(16'h0010, 1);
        rd(16'h0010, 1, "basic");

        // Sequential wrap through the top of the array.
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wr(16'h00FF, 2);
        rd(16'h00FF, 1, "wrap_ff");
        rd(16'h0000, 1, "wrap_00");
        rd(16'h00FF, 2, "wrap_burst");

        // Upper address bits alias.
        wbuf[0] = 8'h7E;
        wr(16'h1234, 1);
        rd(16'h0034, 1, "alias");

        // Unknown instruction: bus stays tristated and memory is untouched.
        wbuf[0] = 8'hA5;
        wr(16'h0040, 1);
        cs = 1'b0;
        @(negedge gck);
        send_byte(8'h05);
        chk("ign_oe_instr", 16'(oe_or), 16'd0);
        send_byte(8'h00);
        chk("ign_oe_a1", 16'(oe_or), 16'd0);
        send_byte(8'h40);
        chk("ign_oe_a0", 16'(oe_or), 16'd0);
        send_byte(8'h5A);
        chk("ign_oe_d", 16'(oe_or), 16'd0);
        end_txn();
        rd(16'h0040, 1, "ignore");

        // Chip select raised after only the high nibble: no write.
        wbuf[0] = 8'h3C;
        wr(16'h0020, 1);
        begin_txn(8'h02, 16'h0020);
        beat(4'hF);
        end_txn();
        rd(16'h0020, 1, "partial");

        // Rise coinciding with chip select deassert: CS wins, no write.
        wbuf[0] = 8'h5A;
        wr(16'h0030, 1);
        begin_txn(8'h02, 16'h0030);
        beat(4'hC);
        sck    = 1'b0;
        sio_in = 4'h3;
        repeat (2) @(negedge gck);
        sck = 1'b1;
        cs  = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        repeat (2) @(negedge gck);
        rd(16'h0030, 1, "cs_race");

        // Asynchronous reset in the middle of a read.
        begin_txn(8'h03, 16'h0010);
        send_byte(8'h00);
        beat(4'h0);
        chk("rst_pre_oe", 16'(rd_oe), 16'd1);
        chk("rst_pre_sio", 16'(rd_n), 16'hA);
        rst = 1'b1;
        #1;
        chk("rst_mid_oe", 16'(oe), 16'd0);
        chk("rst_mid_sio", 16'(sio_out), 16'd0);
        sck = 1'b0;
        cs  = 1'b1;
        @(negedge gck);
        rst = 1'b0;
        repeat (2) @(negedge gck);
        rd(16'h0010, 1, "post_rst");

        // Randomized bursts, read back through an aliased address.
        for (int it = 0; it < 12; it++) begin
            r = $urandom;
            a = r[15:0];
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                r       = $urandom;
                wbuf[i] = r[7:0];
            end
            wr(a, n);
            r = $urandom;
            rd({r[7:0], a[7:0]}, n + 1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idli_sqi_mem_m.md
IDLI_SQI_MEM_M -- requirements
Module: idli_sqi_mem_m

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the number of byte address bits; storage is 2^ADDR_W bytes.
REQ-002 The block SHALL have port i_mem_gck, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port i_mem_rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_mem_sck, input, 1, SQI serial clock from the controller, sampled as data on i_mem_gck.
REQ-005 The block SHALL have port i_mem_cs, input, 1, chip select, active-low.
REQ-006 The block SHALL have port i_mem_sio, input, 4, nibble driven by the controller.
REQ-007 The block SHALL have port o_mem_sio, output, 4, read nibble driven to the controller.
REQ-008 The block SHALL have port o_mem_sio_oe, output, 1, high while o_mem_sio carries read data.

Function
REQ-009 The block SHALL flop i_mem_sck into sck_q each cycle; rise event = i_mem_sck & ~sck_q, fall event = ~i_mem_sck & sck_q.
REQ-010 When i_mem_cs=1 in any cycle, the block SHALL ignore SCK events and, on the next edge, set state=INSTR, nibble counter=0, half flag=0, o_mem_sio_oe=0, discarding partial instr/address/byte.
REQ-011 When i_mem_cs=0 and a rise event occurs, the block SHALL sample i_mem_sio in that cycle; with no event, state SHALL hold.
REQ-012 States SHALL be INSTR, ADDR, DUMMY, RDATA, WDATA, IGNORE; all nibbles are transferred MSB-nibble first.
REQ-013 INSTR SHALL collect 2 nibbles; on the 2nd rise: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-014 ADDR SHALL collect 4 nibbles into a 16b address; on the 4th rise, the address register SHALL load bits [ADDR_W-1:0], so upper bits are ignored and alias.
REQ-015 After ADDR, read SHALL go to DUMMY and write SHALL go to WDATA, with half flag=0.
REQ-016 DUMMY SHALL consume 2 rise events, ignoring sampled data, then go to RDATA.
REQ-017 In RDATA, on each fall event, the block SHALL register o_mem_sio = mem[addr][7:4] if half=0, else mem[addr][3:0], and set o_mem_sio_oe=1; data is valid from the cycle after the fall event until the next fall event.
REQ-018 In RDATA, on each rise event, the block SHALL toggle half; if half was 1, it SHALL set addr = addr+1 modulo 2^ADDR_W.
REQ-019 In WDATA, on a rise event with half=0, the block SHALL store the nibble in a holding register.
REQ-020 In WDATA, on a rise event with half=1, the block SHALL write mem[addr] = {held, i_mem_sio} in that cycle's edge and increment addr modulo 2^ADDR_W.
REQ-021 In WDATA, the block SHALL toggle half on each rise event.
REQ-022 IGNORE SHALL stay until CS goes high; o_mem_sio_oe SHALL be 0 and memory SHALL be unchanged.
REQ-023 o_mem_sio_oe SHALL be 0 in every state other than RDATA.
REQ-024 Transactions SHALL be unbounded in length and wrap sequentially through the array.
REQ-025 If a rise and a CS deassert coincide in one cycle, CS SHALL win: no sample, no write.

Reset
REQ-026 While i_mem_rst=1, without waiting for a clock edge, the block SHALL set state=INSTR, counters=0, half=0, sck_q=0, o_mem_sio=0, o_mem_sio_oe=0.
REQ-027 The memory array SHALL NOT be reset; reads of never-written bytes return unspecified data.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction; an incomplete byte SHALL NOT be written.

Verification
REQ-029 Bench SHALL cover: CS low, write 0x02, address 0x0010, data 0xA5 then CS high; then read 0x03, address 0x0010, dummy byte -> o_mem_sio 0xA then 0x5, with oe=1.
REQ-030 Bench SHALL cover: write 0x11,0x22 starting at address 0x00FF (ADDR_W=8) -> read at 0x00FF returns 0x11, and read at 0x0000 returns 0x22.
REQ-031 Bench SHALL cover: write address 0x1234 with data 0x7E -> read at 0x0034 returns 0x7E.
REQ-032 Bench SHALL cover: instr 0x05, then address and data nibbles -> oe stays 0 throughout; a prior 0xA5 at the target address is still read back.
REQ-033 Bench SHALL cover: write to 0x0020 with CS raised after the high nibble only -> a subsequent read returns the previous contents.
REQ-034 Bench SHALL cover: i_mem_rst pulsed during RDATA with oe=1 -> oe=0 and o_mem_sio=0 in the same cycle, and the next transaction decodes normally.
